serial_word_collector: RTL and testbench

- Downstream consumer of the 4-bit shift register's serial output (S_OUT) while that register runs in shift mode.
- Hunts for a sync nibble in the bit stream, then assembles the following WORD_W bits into a parallel word.
- Buffers assembled words in a 2-entry FIFO and presents them on a valid/ready interface to the next stage.

---
 rtl/serial_word_collector.sv | 239 +++++++++++++++++++++++
 tb/tb_serial_word_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector: hunts for a sync nibble in a serial bit stream,
// assembles the following WORD_W data bits into a word and queues it in a
// 2-entry FIFO with a valid/ready output interface.
// Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit per frame).
module serial_word_collector #(
   parameter int unsigned       WORD_W   = 8,
   parameter int unsigned       SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b0110
) (
   input  logic              CLK,
   input  logic              RESET_L,
   input  logic              BIT_VLD,
   input  logic              BIT_IN,
   input  logic              DIR,
   input  logic              WORD_RDY,
   input  logic              CLR_FLAGS,
   output logic [WORD_W-1:0] WORD_OUT,
   output logic              WORD_VLD,
   output logic              LOCKED,
   output logic              OVF,
   output logic              PAR_ERR
);

   localparam int unsigned BCNT_W = $clog2(WORD_W) + 1;
   localparam int unsigned WCNT_W = $clog2(SYNC_W) + 1;

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_COLLECT = 2'd1,
      S_PARITY  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_COLLECT = 2'd1
   } state_t;
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SYNC_W-1:0]   r_win;
   logic [SYNC_W-1:0]   w_win_nxt;
   logic [WCNT_W-1:0]   r_win_cnt;
   logic [WCNT_W-1:0]   w_win_cnt_nxt;
   logic [BCNT_W-1:0]   r_bit_cnt;
   logic [BCNT_W-1:0]   w_bit_cnt_nxt;
   logic [WORD_W-1:0]   r_shift;
   logic [WORD_W-1:0]   w_shift_nxt;
   logic                r_dir;
   logic                w_dir_nxt;
   logic                w_push;
   logic [WORD_W-1:0]   w_push_data;

   logic [SYNC_W-1:0]   w_win_shift;
   logic [WCNT_W-1:0]   w_win_cnt_inc;
   logic                w_dir_use;
   logic [WORD_W-1:0]   w_shift_in;
   logic                w_last_bit;

`ifdef PARITY_CHECK_EN
   logic                r_par;
   logic                w_par_nxt;
   logic                w_par_fail;
   logic                r_par_err;
`endif

   // FIFO storage and output registers
   logic [WORD_W-1:0]   r_mem [2];
   logic                r_rd_ptr;
   logic                r_wr_ptr;
   logic [1:0]          r_count;
   logic [1:0]          w_count_nxt;
   logic                w_rd_ptr_nxt;
   logic                w_wr_ptr_nxt;
   logic                w_pop;
   logic                w_full;
   logic                w_accept;
   logic                w_drop;
   logic [WORD_W-1:0]   w_head_nxt;
   logic [WORD_W-1:0]   r_word_out;
   logic                r_word_vld;
   logic                r_locked;
   logic                r_ovf;

   // Datapath helpers: window shift, saturating count, direction-aware word shift
   assign w_win_shift   = {r_win[SYNC_W-2:0], BIT_IN};
   assign w_win_cnt_inc = (r_win_cnt == WCNT_W'(SYNC_W)) ? r_win_cnt : r_win_cnt + WCNT_W'(1);
   assign w_dir_use     = (r_bit_cnt == '0) ? DIR : r_dir;
   assign w_shift_in    = w_dir_use ? {r_shift[WORD_W-2:0], BIT_IN} : {BIT_IN, r_shift[WORD_W-1:1]};
   assign w_last_bit    = (r_bit_cnt == BCNT_W'(WORD_W - 1));

   // Next-state and frame-assembly logic
   always_comb begin
      w_state_nxt   = r_state;
      w_win_nxt     = r_win;
      w_win_cnt_nxt = r_win_cnt;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_dir_nxt     = r_dir;
      w_push        = 1'b0;
      w_push_data   = r_shift;
`ifdef PARITY_CHECK_EN
      w_par_nxt     = r_par;
      w_par_fail    = 1'b0;
`endif
      if (BIT_VLD) begin
         case (r_state)
            S_HUNT: begin
               w_win_nxt     = w_win_shift;
               w_win_cnt_nxt = w_win_cnt_inc;
               if ((w_win_cnt_inc == WCNT_W'(SYNC_W)) && (w_win_shift == SYNC_PAT)) begin
                  w_state_nxt   = S_COLLECT;
                  w_bit_cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
                  w_par_nxt     = 1'b0;
`endif
               end
            end
            S_COLLECT: begin
               w_shift_nxt = w_shift_in;
               w_dir_nxt   = w_dir_use;
`ifdef PARITY_CHECK_EN
               w_par_nxt   = r_par ^ BIT_IN;
`endif
               if (w_last_bit) begin
                  w_bit_cnt_nxt = '0;
                  w_win_nxt     = '0;
                  w_win_cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
                  w_state_nxt   = S_PARITY;
`else
                  w_state_nxt   = S_HUNT;
                  w_push        = 1'b1;
                  w_push_data   = w_shift_in;
`endif
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
               end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
               w_state_nxt = S_HUNT;
               if (BIT_IN == r_par) begin
                  w_push = 1'b1;
               end else begin
                  w_par_fail = 1'b1;
               end
            end
`endif
            default: begin
               w_state_nxt = S_HUNT;
            end
         endcase
      end
   end

   // FIFO control: accept/drop decision, occupancy and next head value
   assign w_pop        = r_word_vld & WORD_RDY;
   assign w_full       = (r_count == 2'd2);
   assign w_accept     = w_push & (~w_full | w_pop);
   assign w_drop       = w_push & w_full & ~w_pop;
   assign w_rd_ptr_nxt = r_rd_ptr ^ w_pop;
   assign w_wr_ptr_nxt = r_wr_ptr ^ w_accept;

   always_comb begin
      w_count_nxt = r_count;
      w_head_nxt  = r_word_out;
      if (w_accept && !w_pop) begin
         w_count_nxt = r_count + 2'd1;
      end else if (!w_accept && w_pop) begin
         w_count_nxt = r_count - 2'd1;
      end
      if (w_count_nxt != 2'd0) begin
         if (w_accept && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_push_data;
         end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
         end
      end
   end

   // State, datapath, FIFO and flag registers
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_state    <= S_HUNT;
         r_win      <= '0;
         r_win_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_dir      <= 1'b0;
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_word_out <= '0;
         r_word_vld <= 1'b0;
         r_locked   <= 1'b0;
         r_ovf      <= 1'b0;
`ifdef PARITY_CHECK_EN
         r_par      <= 1'b0;
         r_par_err  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_win      <= w_win_nxt;
         r_win_cnt  <= w_win_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_dir      <= w_dir_nxt;
         if (w_accept) begin
            r_mem[r_wr_ptr] <= w_push_data;
         end
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_count    <= w_count_nxt;
         r_word_out <= w_head_nxt;
         r_word_vld <= (w_count_nxt != 2'd0);
         r_locked   <= (w_state_nxt != S_HUNT);
         r_ovf      <= w_drop | (r_ovf & ~CLR_FLAGS);
`ifdef PARITY_CHECK_EN
         r_par      <= w_par_nxt;
         r_par_err  <= w_par_fail | (r_par_err & ~CLR_FLAGS);
`endif
      end
   end

   assign WORD_OUT = r_word_out;
   assign WORD_VLD = r_word_vld;
   assign LOCKED   = r_locked;
   assign OVF      = r_ovf;
`ifdef PARITY_CHECK_EN
   assign PAR_ERR  = r_par_err;
`else
   assign PAR_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector; covers both builds of PARITY_CHECK_EN.
module tb_serial_word_collector;

   logic       CLK;
   logic       RESET_L;
   logic       BIT_VLD;
   logic       BIT_IN;
   logic       DIR;
   logic       WORD_RDY;
   logic       CLR_FLAGS;
   logic [7:0] WORD_OUT;
   logic       WORD_VLD;
   logic       LOCKED;
   logic       OVF;
   logic       PAR_ERR;

   int n_tests = 0;
   int n_fail  = 0;
   int lock_cnt;
   bit vld_before;

`ifdef PARITY_CHECK_EN
   localparam int LOCK_EXP = 9;
`else
   localparam int LOCK_EXP = 8;
`endif

   serial_word_collector dut (
      .CLK       (CLK),
      .RESET_L   (RESET_L),
      .BIT_VLD   (BIT_VLD),
      .BIT_IN    (BIT_IN),
      .DIR       (DIR),
      .WORD_RDY  (WORD_RDY),
      .CLR_FLAGS (CLR_FLAGS),
      .WORD_OUT  (WORD_OUT),
      .WORD_VLD  (WORD_VLD),
      .LOCKED    (LOCKED),
      .OVF       (OVF),
      .PAR_ERR   (PAR_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Safety net against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, then sample 1 time unit after the rising edge
   task automatic step(input logic v, input logic b);
      BIT_VLD = v;
      BIT_IN  = b;
      @(posedge CLK);
      #1;
   endtask

   // Sync nibble, 8 data bits (seq MSB first), then parity bit in the parity build.
   // last_mode: 1 raises WORD_RDY on the final bit, 2 pulses CLR_FLAGS on the final bit.
   task automatic send_frame(input logic [7:0] seq, input bit flip, input bit bad_par,
                             input bit gap, input int last_mode);
      logic [12:0] bits;
      logic        b;
      int          n;
      bits = {4'b0110, seq, (^seq) ^ bad_par};
`ifdef PARITY_CHECK_EN
      n = 13;
`else
      n = 12;
`endif
      lock_cnt   = 0;
      vld_before = 1'b0;
      for (int k = 0; k < n; k++) begin
         b = bits[12-k];
         if (gap) step(1'b0, ~b);
         if (k == n-1 && last_mode == 1) WORD_RDY  = 1'b1;
         if (k == n-1 && last_mode == 2) CLR_FLAGS = 1'b1;
         step(1'b1, b);
         CLR_FLAGS = 1'b0;
         if (flip && k == 4) DIR = ~DIR;
         if (LOCKED) lock_cnt++;
         if (k != n-1 && WORD_VLD) vld_before = 1'b1;
      end
      BIT_VLD = 1'b0;
   endtask

   initial begin
      RESET_L   = 1'b0;
      BIT_VLD   = 1'b0;
      BIT_IN    = 1'b0;
      DIR       = 1'b1;
      WORD_RDY  = 1'b1;
      CLR_FLAGS = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_word_out", 32'(WORD_OUT), 32'h0);
      check("rst_word_vld", 32'(WORD_VLD), 32'h0);
      check("rst_locked",   32'(LOCKED),   32'h0);
      check("rst_ovf",      32'(OVF),      32'h0);
      check("rst_par_err",  32'(PAR_ERR),  32'h0);
      RESET_L = 1'b1;
      step(1'b0, 1'b0);

      // Basic frame, MSB first
      send_frame(8'hB2, 1'b0, 1'b0, 1'b0, 0);
      check("t1_word_out",   32'(WORD_OUT),   32'hB2);
      check("t1_word_vld",   32'(WORD_VLD),   32'h1);
      check("t1_locked_end", 32'(LOCKED),     32'h0);
      check("t1_lock_cycles", 32'(lock_cnt),  32'(LOCK_EXP));
      check("t1_no_early_vld", 32'(vld_before), 32'h0);
      step(1'b0, 1'b0);
      check("t1_vld_one_cycle", 32'(WORD_VLD), 32'h0);
      check("t1_out_hold",    32'(WORD_OUT),  32'hB2);

      // LSB first; DIR flips after the first data bit and must be ignored
      DIR = 1'b0;
      send_frame(8'hB2, 1'b1, 1'b0, 1'b0, 0);
      check("t2_word_out", 32'(WORD_OUT), 32'h4D);
      check("t2_word_vld", 32'(WORD_VLD), 32'h1);
      step(1'b0, 1'b0);
      DIR = 1'b1;

      // Overflow: three frames with downstream stalled
      WORD_RDY = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
      check("t3_first_out", 32'(WORD_OUT), 32'hA5);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
      check("t3_head_kept", 32'(WORD_OUT), 32'hA5);
      check("t3_no_ovf",    32'(OVF),      32'h0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 0);
      check("t3_ovf_set",   32'(OVF),      32'h1);
      check("t3_head_after_drop", 32'(WORD_OUT), 32'hA5);
      WORD_RDY = 1'b1;
      step(1'b0, 1'b0);
      check("t3_second_out", 32'(WORD_OUT), 32'h3C);
      check("t3_second_vld", 32'(WORD_VLD), 32'h1);
      step(1'b0, 1'b0);
      check("t3_drained",    32'(WORD_VLD), 32'h0);
      check("t3_ovf_sticky", 32'(OVF),      32'h1);
      CLR_FLAGS = 1'b1;
      step(1'b0, 1'b0);
      CLR_FLAGS = 1'b0;
      check("t3_ovf_clr",    32'(OVF),      32'h0);

      // Stream gapped by BIT_VLD low every other cycle, garbage on BIT_IN
      send_frame(8'hB2, 1'b0, 1'b0, 1'b1, 0);
      check("t4_word_out",     32'(WORD_OUT),   32'hB2);
      check("t4_word_vld",     32'(WORD_VLD),   32'h1);
      check("t4_no_early_vld", 32'(vld_before), 32'h0);
      step(1'b0, 1'b0);

      // Reset mid-frame with a word waiting in the FIFO
      WORD_RDY = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
      check("t5_pre_vld", 32'(WORD_VLD), 32'h1);
      step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
      step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      check("t5_locked_mid", 32'(LOCKED), 32'h1);
      BIT_VLD = 1'b0;
      RESET_L = 1'b0;
      #1;
      check("t5_rst_locked", 32'(LOCKED),   32'h0);
      check("t5_rst_vld",    32'(WORD_VLD), 32'h0);
      check("t5_rst_out",    32'(WORD_OUT), 32'h0);
      @(posedge CLK);
      #1;
      RESET_L  = 1'b1;
      WORD_RDY = 1'b1;
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0);
      check("t5_after_out", 32'(WORD_OUT), 32'h81);
      check("t5_after_vld", 32'(WORD_VLD), 32'h1);
      step(1'b0, 1'b0);

      // Push into a full FIFO with a simultaneous pop
      WORD_RDY = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1);
      check("t6_no_ovf",  32'(OVF),      32'h0);
      check("t6_head",    32'(WORD_OUT), 32'h22);
      step(1'b0, 1'b0);
      check("t6_third",   32'(WORD_OUT), 32'h33);
      check("t6_third_vld", 32'(WORD_VLD), 32'h1);
      step(1'b0, 1'b0);
      check("t6_empty",   32'(WORD_VLD), 32'h0);

      // Overflow event and CLR_FLAGS in the same cycle: set wins
      WORD_RDY = 1'b0;
      send_frame(8'h44, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0);
      send_frame(8'h66, 1'b0, 1'b0, 1'b0, 2);
      check("t7_set_wins", 32'(OVF), 32'h1);
      CLR_FLAGS = 1'b1;
      step(1'b0, 1'b0);
      CLR_FLAGS = 1'b0;
      check("t7_clr", 32'(OVF), 32'h0);
      WORD_RDY = 1'b1;
      step(1'b0, 1'b0);
      check("t7_second", 32'(WORD_OUT), 32'h55);
      step(1'b0, 1'b0);
      check("t7_empty",  32'(WORD_VLD), 32'h0);
      check("t7_hold",   32'(WORD_OUT), 32'h55);

`ifdef PARITY_CHECK_EN
      // Parity good then bad
      send_frame(8'hB2, 1'b0, 1'b0, 1'b0, 0);
      check("t8_good_out", 32'(WORD_OUT), 32'hB2);
      check("t8_good_vld", 32'(WORD_VLD), 32'h1);
      check("t8_good_perr", 32'(PAR_ERR), 32'h0);
      step(1'b0, 1'b0);
      send_frame(8'hB2, 1'b0, 1'b1, 1'b0, 0);
      check("t8_bad_vld",  32'(WORD_VLD), 32'h0);
      check("t8_bad_perr", 32'(PAR_ERR),  32'h1);
      check("t8_bad_ovf",  32'(OVF),      32'h0);
      CLR_FLAGS = 1'b1;
      step(1'b0, 1'b0);
      CLR_FLAGS = 1'b0;
      check("t8_perr_clr", 32'(PAR_ERR), 32'h0);
`else
      check("par_err_tied", 32'(PAR_ERR), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
